// File: rtl/mem_line_pkg.sv
// Shared constants and FSM state type for the 256-bit line memory responder.
package mem_line_pkg;

  localparam int LINE_W      = 256;
  localparam int ADDR_W      = 32;
  localparam int LINE_OFFSET = 5;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK,
    RECOVER
  } resp_state_t;

endpackage

// File: rtl/line_store.sv
// DEPTH x LINE_W backing array: synchronous write, asynchronous read.
module line_store #(
  parameter int LINE_W = 256,
  parameter int DEPTH  = 512,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  idx,
  input  logic [LINE_W-1:0] wr_data,
  output logic [LINE_W-1:0] rd_data
);

  logic [LINE_W-1:0] memory [DEPTH];

  // NOTE: the array has no reset; line contents must survive a responder reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      memory[idx] <= wr_data;
    end
  end

  assign rd_data = memory[idx];

endmodule

// File: rtl/line_mem_responder.sv
// Memory-side responder for the dcache 256-bit line refill/write-back port.
// Optional saturating read/write counters are enabled with LINE_MEM_STATS_EN.
module line_mem_responder
  import mem_line_pkg::*;
#(
  parameter int LINE_W  = mem_line_pkg::LINE_W,
  parameter int ADDR_W  = mem_line_pkg::ADDR_W,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
`ifdef LINE_MEM_STATS_EN
  ,
  output logic [31:0]       rd_count_o,
  output logic [31:0]       wr_count_o
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  resp_state_t       state;
  logic [CNT_W-1:0]  count;
  logic [IDX_W-1:0]  req_idx;
  logic              req_write;
  logic [LINE_W-1:0] req_data;

  logic [IDX_W-1:0]  addr_idx;
  logic [IDX_W-1:0]  store_idx;
  logic              store_we;
  logic [LINE_W-1:0] store_rdata;
  logic              unused_addr_bits;

  // Byte offset and bits above the line index are don't-care: addresses wrap modulo DEPTH.
  assign addr_idx         = addr_i[LINE_OFFSET +: IDX_W];
  assign unused_addr_bits = ^{addr_i[ADDR_W-1:LINE_OFFSET+IDX_W], addr_i[LINE_OFFSET-1:0]};

  // The live address is only looked at in IDLE (zero-wait LATENCY=1 read); afterwards the latched index rules.
  assign store_idx = (state == IDLE) ? addr_idx : req_idx;
  assign store_we  = (state == ACK) && req_write;

  line_store #(
    .LINE_W (LINE_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_store (
    .clk_i   (clk_i),
    .wr_en   (store_we),
    .idx     (store_idx),
    .wr_data (req_data),
    .rd_data (store_rdata)
  );

  // NOTE: all state here is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      count     <= '0;
      ack_o     <= 1'b0;
      data_o    <= '0;
      req_idx   <= '0;
      req_write <= 1'b0;
      req_data  <= '0;
    end else begin
      ack_o  <= 1'b0;
      data_o <= '0;
      unique case (state)
        IDLE: begin
          if (enable_i) begin
            req_idx   <= addr_idx;
            req_write <= write_i;
            req_data  <= data_i;
            count     <= CNT_LOAD;
            if (LATENCY == 1) begin
              state  <= ACK;
              ack_o  <= 1'b1;
              data_o <= write_i ? '0 : store_rdata;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          count <= count - CNT_LAST;
          // The counter reaches zero on the same edge that enters ACK.
          if (count == CNT_LAST) begin
            state  <= ACK;
            ack_o  <= 1'b1;
            data_o <= req_write ? '0 : store_rdata;
          end
        end
        ACK:     state <= RECOVER;
        RECOVER: state <= IDLE;
      endcase
    end
  end

`ifdef LINE_MEM_STATS_EN
  logic [31:0] rd_count_q;
  logic [31:0] wr_count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else if (state == ACK) begin
      if (!req_write && (rd_count_q != '1)) rd_count_q <= rd_count_q + 32'd1;
      if (req_write && (wr_count_q != '1))  wr_count_q <= wr_count_q + 32'd1;
    end
  end

  assign rd_count_o = rd_count_q;
  assign wr_count_o = wr_count_q;
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
// Scoreboard bench for line_mem_responder: a driver predicts each ack (cycle and data)
// from a plain line-array model; an independent monitor compares whatever the DUT presents.
module tb_line_mem_responder;
  import mem_line_pkg::*;

  localparam int DEPTH   = 512;
  localparam int LATENCY = 10;
  localparam int NLINES  = 64;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [ADDR_W-1:0] addr_i;
  logic [LINE_W-1:0] data_i;
  logic              enable_i;
  logic              write_i;
  logic              ack_o;
  logic [LINE_W-1:0] data_o;
`ifdef LINE_MEM_STATS_EN
  logic [31:0]       rd_count_o;
  logic [31:0]       wr_count_o;
`endif

  line_mem_responder #(
    .LINE_W  (LINE_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .enable_i   (enable_i),
    .write_i    (write_i),
    .ack_o      (ack_o),
    .data_o     (data_o)
`ifdef LINE_MEM_STATS_EN
    ,
    .rd_count_o (rd_count_o),
    .wr_count_o (wr_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // cyc = number of rising edges so far; sampled at falling edges it names the current cycle.
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [LINE_W-1:0] data;
    int                ack_cyc;
    string             name;
  } exp_t;

  exp_t              exp_q[$];
  logic [LINE_W-1:0] ref_mem [DEPTH];
  int                checks    = 0;
  int                failures  = 0;
  int                next_free = 0;
  int                n_reads   = 0;
  int                n_writes  = 0;

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int line_of(input logic [ADDR_W-1:0] addr);
    return int'((addr >> LINE_OFFSET) % DEPTH);
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Random address hitting line 'line' with random byte offset and random upper (wrapping) bits.
  function automatic logic [ADDR_W-1:0] addr_for(input int line);
    logic [ADDR_W-1:0] a;
    a = $urandom;
    a[13:5] = 9'(line);
    return a;
  endfunction

  task automatic wait_free();
    while (cyc + 1 < next_free) @(negedge clk_i);
  endtask

  // One request. Edge A (cyc+1) accepts it; ack is seen while cyc == A+LATENCY-1;
  // the next request can be accepted at edge A+LATENCY+2.
  // mode 0: hold enable until ack; 1: perturb addr/write/data mid-BUSY; 2: drop enable mid-BUSY.
  task automatic do_req(input bit wr, input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] d,
                        input string name, input int mode);
    exp_t e;
    int   a;
    wait_free();
    enable_i = 1'b1;
    write_i  = wr;
    addr_i   = addr;
    data_i   = d;
    a         = cyc + 1;
    e.ack_cyc = a + LATENCY - 1;
    e.name    = name;
    if (wr) begin
      e.data = '0;
      ref_mem[line_of(addr)] = d;
      n_writes++;
    end else begin
      e.data = ref_mem[line_of(addr)];
      n_reads++;
    end
    exp_q.push_back(e);
    next_free = a + LATENCY + 2;
    @(negedge clk_i);
    if (mode == 1) begin
      repeat (2) @(negedge clk_i);
      addr_i  = addr + 32'h20;
      write_i = ~wr;
      data_i  = rand_line();
    end else if (mode == 2) begin
      @(negedge clk_i);
      enable_i = 1'b0;
    end
    while (cyc < e.ack_cyc) @(negedge clk_i);
    enable_i = 1'b0;
    write_i  = $urandom_range(0, 1);
    addr_i   = $urandom;
  endtask

  // Monitor: compares every presented ack against the oldest prediction, flags missing or extra acks.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        while (exp_q.size() > 0 && cyc > exp_q[0].ack_cyc) begin
          e = exp_q.pop_front();
          check({e.name, "_missing_ack"}, 0, 1);
        end
        if (ack_o) begin
          if (exp_q.size() == 0) begin
            check("unexpected_ack", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check({e.name, "_ack_cycle"}, cyc, e.ack_cyc);
            check({e.name, "_data"}, data_o, e.data);
          end
        end else begin
          check("data_idle_zero", data_o, '0);
        end
      end
    end
  end

  initial begin
    int a;
    int drain;
    logic [LINE_W-1:0] v;
    exp_t e;

    rst_i    = 1'b1;
    enable_i = 1'b0;
    write_i  = 1'b0;
    addr_i   = '0;
    data_i   = '0;
    #1;
    check("reset_ack", ack_o, 1'b0);
    check("reset_data", data_o, '0);
    check("reset_state", dut.state, IDLE);
    check("reset_count", dut.count, '0);
    repeat (2) @(negedge clk_i);
    rst_i     = 1'b0;
    next_free = cyc + 1;

    // Fill the lines the bench uses; line 0 gets 5.
    for (int i = 0; i < NLINES; i++) begin
      v = (i == 0) ? LINE_W'(5) : rand_line();
      do_req(1'b1, addr_for(i), v, "preload_wr", 0);
    end

    do_req(1'b0, 32'h0000_0000, '0, "read_line0", 0);

    // Write then read line 32: second ack exactly LATENCY+2 cycles after the first.
    do_req(1'b1, 32'h0000_0400, LINE_W'(32'hDEAD_BEEF), "wr_0400", 0);
    do_req(1'b0, 32'h0000_0400, '0, "rd_0400", 0);
    @(negedge clk_i);
    check("mem32_peek", dut.u_store.memory[32], LINE_W'(32'hDEAD_BEEF));

    // Enable held high across three back-to-back reads of line 3.
    wait_free();
    enable_i = 1'b1;
    write_i  = 1'b0;
    addr_i   = 32'h0000_0060;
    a = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      e.ack_cyc = a + k * (LATENCY + 2) + LATENCY - 1;
      e.data    = ref_mem[3];
      e.name    = "held_rd";
      exp_q.push_back(e);
      n_reads++;
    end
    next_free = a + 3 * (LATENCY + 2);
    while (cyc < a + 2 * (LATENCY + 2) + LATENCY - 1) @(negedge clk_i);
    enable_i = 1'b0;

    // Mid-BUSY change of addr 0x20 -> 0x40 and write flip: line 1 read completes, line 2 untouched.
    do_req(1'b0, 32'h0000_0020, '0, "perturb_rd", 1);
    @(negedge clk_i);
    check("line2_untouched", dut.u_store.memory[2], ref_mem[2]);

    // Reset during BUSY of a write to line 3: no ack, no commit.
    wait_free();
    enable_i = 1'b1;
    write_i  = 1'b1;
    addr_i   = 32'h0000_0060;
    data_i   = rand_line();
    repeat (4) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("midrst_ack", ack_o, 1'b0);
    check("midrst_data", data_o, '0);
    enable_i = 1'b0;
    repeat (LATENCY + 2) @(negedge clk_i);
    check("midrst_mem3", dut.u_store.memory[3], ref_mem[3]);
    rst_i = 1'b0;
    next_free = cyc + 1;
    do_req(1'b0, 32'h0000_0060, '0, "post_rst_rd", 0);
`ifdef LINE_MEM_STATS_EN
    n_reads  = 1;
    n_writes = 0;
`endif

    // Randomized traffic over the preloaded lines.
    for (int i = 0; i < 40; i++) begin
      do_req(1'($urandom_range(0, 1)), addr_for($urandom_range(0, NLINES - 1)), rand_line(),
             "rand", $urandom_range(0, 2));
    end

    drain = 0;
    while (exp_q.size() > 0 && drain < 4 * LATENCY) begin
      @(negedge clk_i);
      drain++;
    end
    if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);

`ifdef LINE_MEM_STATS_EN
    repeat (3) @(negedge clk_i);
    check("stats_rd", rd_count_o, n_reads);
    check("stats_wr", wr_count_o, n_writes);
    dut.rd_count_q = 32'hFFFF_FFFF;
    do_req(1'b0, 32'h0000_0000, '0, "sat_rd", 0);
    repeat (3) @(negedge clk_i);
    check("stats_rd_sat", rd_count_o, 32'hFFFF_FFFF);
    check("stats_wr_after_sat", wr_count_o, n_writes);
`endif

    repeat (3) @(negedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
